// File: rtl/vreg_file_wb_if.sv
// ---------------------------------------------------------------------------
// vreg_file_wb_if
//   Bundles the signals that run between the SIMD pipeline and the writeback
//   stage / vector register file.
//
//   master : pipeline side. Drives the ALU commit request and the decode read
//            addresses. Receives the read data and the WB forwarding copy.
//   slave  : register file side. The opposite direction of every signal.
//
//   Signals (bit 0 is the MSB throughout):
//     ALU_output [0:DATA_W-1]  result to commit
//     ALU_PPPWW  [0:4]         [0:2] participation PPP, [3:4] element width WW
//     ALU_rD     [0:ADDR_W-1]  destination register
//     ALU_WB_en                commit request this cycle
//     ID_rA_addr/ID_rB_addr    decode read addresses
//     ID_rA_data/ID_rB_data    decode read data (combinational)
//     WB_data/WB_rD/WB_mask/WB_valid  registered copy of the last commit
// ---------------------------------------------------------------------------
interface vreg_file_wb_if #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int BYTES  = DATA_W / 8;

  logic [0:DATA_W-1] ALU_output;
  logic [0:4]        ALU_PPPWW;
  logic [0:ADDR_W-1] ALU_rD;
  logic              ALU_WB_en;

  logic [0:ADDR_W-1] ID_rA_addr;
  logic [0:ADDR_W-1] ID_rB_addr;
  logic [0:DATA_W-1] ID_rA_data;
  logic [0:DATA_W-1] ID_rB_data;

  logic [0:DATA_W-1] WB_data;
  logic [0:ADDR_W-1] WB_rD;
  logic [0:BYTES-1]  WB_mask;
  logic              WB_valid;

  modport master (
    output ALU_output, ALU_PPPWW, ALU_rD, ALU_WB_en,
    output ID_rA_addr, ID_rB_addr,
    input  ID_rA_data, ID_rB_data,
    input  WB_data, WB_rD, WB_mask, WB_valid
  );

  modport slave (
    input  ALU_output, ALU_PPPWW, ALU_rD, ALU_WB_en,
    input  ID_rA_addr, ID_rB_addr,
    output ID_rA_data, ID_rB_data,
    output WB_data, WB_rD, WB_mask, WB_valid
  );
endinterface

// File: rtl/vreg_file_wb.sv
// ---------------------------------------------------------------------------
// vreg_file_wb
//   Writeback stage and NUM_REGS x DATA_W vector register file of the SIMD
//   pipeline. Bit 0 is the MSB, and byte k covers bits [8k:8k+7].
//
//   The registered ALU result is merged byte-wise into reg[ALU_rD]. The bytes
//   are chosen by a mask that is decoded from the participation field PPP and
//   the element width WW. Two combinational read ports serve decode. A
//   registered copy of the last commit (full merged register value,
//   destination, mask, valid) is kept for forwarding.
//
//   Ports:
//     clk    pipeline clock, rising edge
//     reset  asynchronous, active-high; clears the array and the WB registers
//     bus    vreg_file_wb_if.slave (ALU commit inputs, ID read ports,
//            WB forwarding outputs)
//
//   Build option:
//     VREG_READ_BYPASS_EN  when defined, a read that hits the destination of
//                          a commit in the same cycle returns the merged
//                          value (write-through). When undefined, reads
//                          return the array contents from before the edge.
// ---------------------------------------------------------------------------
module vreg_file_wb #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32
) (
  input  logic          clk,
  input  logic          reset,
  vreg_file_wb_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int BYTES  = DATA_W / 8;

  // Byte mask from the participation field and the element width.
  // Element 0 is the most significant one. An element spans 2**ww bytes.
  function automatic logic [0:BYTES-1] ppp_mask(input logic [0:2] ppp,
                                                input logic [0:1] ww);
    logic [0:BYTES-1] m;
    int               elem;
    m = '0;
    for (int k = 0; k < BYTES; k++) begin
      elem = k >> ww;
      case (ppp)
        3'b000:  m[k] = 1'b1;
        3'b001:  m[k] = (k < BYTES / 2);
        3'b010:  m[k] = (k >= BYTES / 2);
        3'b011:  m[k] = (elem[0] == 1'b0);
        3'b100:  m[k] = (elem[0] == 1'b1);
        default: m[k] = 1'b0;
      endcase
    end
    return m;
  endfunction

  // Bytes with mask=1 take the new data. All other bytes keep the old value.
  function automatic logic [0:DATA_W-1] merge_bytes(input logic [0:DATA_W-1] old_v,
                                                    input logic [0:DATA_W-1] new_v,
                                                    input logic [0:BYTES-1]  mask);
    logic [0:DATA_W-1] r;
    for (int k = 0; k < BYTES; k++)
      r[8*k +: 8] = mask[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
    return r;
  endfunction

  logic [0:DATA_W-1] regs [NUM_REGS];

  // ---- p0: ALU stage outputs, mask decode and merge ----
  logic [0:BYTES-1]  wr_mask_p0;
  logic              commit_p0;
  logic [0:DATA_W-1] merged_p0;

  always_comb begin
    wr_mask_p0 = ppp_mask(bus.ALU_PPPWW[0:2], bus.ALU_PPPWW[3:4]);
    commit_p0  = bus.ALU_WB_en && (|wr_mask_p0);
    merged_p0  = merge_bytes(regs[bus.ALU_rD], bus.ALU_output, wr_mask_p0);
  end

`ifdef VREG_READ_BYPASS_EN
  // merged_p0 is exactly the value the destination holds after this edge.
  always_comb begin
    bus.ID_rA_data = regs[bus.ID_rA_addr];
    bus.ID_rB_data = regs[bus.ID_rB_addr];
    if (commit_p0 && (bus.ID_rA_addr == bus.ALU_rD))
      bus.ID_rA_data = merged_p0;
    if (commit_p0 && (bus.ID_rB_addr == bus.ALU_rD))
      bus.ID_rB_data = merged_p0;
  end
`else
  always_comb begin
    bus.ID_rA_data = regs[bus.ID_rA_addr];
    bus.ID_rB_data = regs[bus.ID_rB_addr];
  end
`endif

  // ---- p1: register file commit and WB forwarding copy ----
  logic [0:DATA_W-1] wb_data_p1;
  logic [0:ADDR_W-1] wb_rd_p1;
  logic [0:BYTES-1]  wb_mask_p1;
  logic              vld_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      wb_data_p1 <= '0;
      wb_rd_p1   <= '0;
      wb_mask_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= commit_p0;
      // With no commit (disabled or empty mask), the array and the WB copy hold.
      if (commit_p0) begin
        regs[bus.ALU_rD] <= merged_p0;
        wb_data_p1       <= merged_p0;
        wb_rd_p1         <= bus.ALU_rD;
        wb_mask_p1       <= wr_mask_p0;
      end
    end
  end

  assign bus.WB_data  = wb_data_p1;
  assign bus.WB_rD    = wb_rd_p1;
  assign bus.WB_mask  = wb_mask_p1;
  assign bus.WB_valid = vld_p1;

endmodule

// File: doc/vreg_file_wb.md
Name: vreg_file_wb

Overview:
- Writeback stage plus 32x64-bit vector register file for the SIMD pipeline.
- Consumes the registered ALU stage outputs (result, PPPWW, rD, WB enable) and commits them to the register file with participation-field byte masking.
- Serves the two decode-stage read ports (rA, rB).
- Emits a registered WB-stage copy of the last commit for forwarding.

Parameters:
- DATA_W, 64, register width in bits; bit 0 is MSB, fixed [0:DATA_W-1] numbering.
- NUM_REGS, 32, register count; address width is 5.
- BYTES, DATA_W/8, byte lanes per register; one mask bit per byte.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- ALU_output  in  [0:63]  result to commit
- ALU_PPPWW  in  [0:4]  [0:2]=PPP participation, [3:4]=WW element width
- ALU_rD  in  [0:4]  destination register
- ALU_WB_en  in  1  commit request this cycle
- ID_rA_addr  in  [0:4]  read port A address
- ID_rB_addr  in  [0:4]  read port B address
- ID_rA_data  out  [0:63]  read port A data (combinational)
- ID_rB_data  out  [0:63]  read port B data (combinational)
- WB_data  out  [0:63]  registered: full post-commit contents of WB_rD
- WB_rD  out  [0:4]  registered: last committed destination
- WB_mask  out  [0:7]  registered: byte mask applied on last commit
- WB_valid  out  1  registered: high the cycle after a commit with non-zero mask

Behaviour:
- Reset (async, immediate):
  - all 32 registers = 0
  - WB_data = 0, WB_rD = 0, WB_mask = 0, WB_valid = 0
  - Read ports then return 0.
- Element width WW: 00 byte (8 elems), 01 half (4), 10 word (2), 11 dword (1). Element 0 is the most significant.
- Byte mask from PPP (mask bit k covers bits [8k:8k+7]):
  - 000 all: 0xFF
  - 001 upper half: 0xF0
  - 010 lower half: 0x0F
  - 011 even elements (0, 2, ...): byte 0xAA, half 0xCC, word 0xF0, dword 0xFF
  - 100 odd elements: byte 0x55, half 0x33, word 0x0F, dword 0x00
  - 101..111 reserved: 0x00, no write
- Commit at posedge when ALU_WB_en=1: reg[ALU_rD] bytes with mask=1 take ALU_output; others hold.
- ALU_WB_en=0 or mask=0x00: no array change; WB_valid falls to 0 next cycle; WB_data, WB_rD and WB_mask hold.
- WB registers update on the same edge as the commit. WB_data holds the merged new full register value, not raw ALU_output.
- Read ports are combinational from the array. Read of the same address on both ports is allowed.
- Same-cycle read/write hazard: handled per Optional Feature.
- Back-to-back commits to the same rD: each merges onto the previous edge's result; no lost bytes.
- Reset asserted mid-commit: reset wins; the array reads 0 after reset deasserts.
- No stalls: one commit accepted every cycle, no backpressure.

Optional Feature:
- Macro: VREG_READ_BYPASS_EN.
- Defined: when ALU_WB_en=1, mask≠0 and ID_rX_addr==ALU_rD, ID_rX_data returns (array & ~bytemask) | (ALU_output & bytemask). This is write-through within the same cycle.
- Not defined: read ports return pre-edge array contents only. Decode must stall or forward one cycle.

Test Plan:
- Reset: assert reset asynchronously between edges -> WB_valid=0 immediately; read of any address = 0x0000000000000000.
- Full write: rD=3, PPP=000, WW=11, data=0x0123456789ABCDEF -> next cycle rA_addr=3 reads 0x0123456789ABCDEF; WB_valid=1, WB_mask=0xFF, WB_rD=3.
- Even bytes: r5 preloaded 0x1111111111111111, write PPP=011 WW=00 data=0xFFFFFFFFFFFFFFFF -> r5=0xFF11FF11FF11FF11, WB_mask=0xAA.
- Odd dword and reserved PPP: PPP=100 WW=11, then PPP=110 -> r unchanged, WB_valid=0 both cycles.
- Back-to-back: r7 written PPP=001 data=0xAAAAAAAA00000000, then PPP=010 data=0x00000000BBBBBBBB -> r7=0xAAAAAAAABBBBBBBB.
- Same-cycle hazard: r9=0, commit r9 PPP=000 data=0x5A5A5A5A5A5A5A5A while rB_addr=9 -> with VREG_READ_BYPASS_EN rB_data=0x5A5A5A5A5A5A5A5A that cycle, without it 0.
